// File: rtl/counter_pkg.sv
// Shared definitions for the mod-2**WIDTH counter family: defaults and mode encoding.
package counter_pkg;

  localparam int unsigned DEF_WIDTH   = 5;
  localparam int unsigned DEF_RST_VAL = 31;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_RELOAD  = 2'b01,
    MODE_ONESHOT = 2'b10
  } mode_e;

  // The unused encoding 2'b11 behaves as plain wrap.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      MODE_RELOAD:  return MODE_RELOAD;
      MODE_ONESHOT: return MODE_ONESHOT;
      default:      return MODE_WRAP;
    endcase
  endfunction

endpackage

// File: rtl/down_counter32_tff_ld.sv
// Single-bit toggle flip-flop with async active-low reset and synchronous load.
module tff_ld #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (t) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/down_counter32.sv
// Loadable modulo-2**WIDTH down counter with wrap, auto-reload and one-shot
// underflow handling, built from a chain of loadable toggle flip-flops.
module down_counter32
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             bt,
  output logic             zero,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] low_zero;
  logic             cnt_zero;
  logic             cnt_ld;
  logic [WIDTH-1:0] cnt_ld_val;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;
  logic             done_q;
  logic             done_d;
  logic             bt_q;
  logic             bt_d;
  mode_e            mode_s;

  assign mode_s   = decode_mode(mode);
  assign cnt_zero = (cnt_q == '0);

  // Bit i of a down counter flips when every lower bit is zero (borrow ripple).
  always_comb begin
    low_zero    = '0;
    low_zero[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      low_zero[i] = low_zero[i-1] & ~cnt_q[i-1];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_ld #(
      .RST_BIT (RST_VAL[i])
    ) u_tff (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (en & low_zero[i]),
      .ld    (cnt_ld),
      .d     (cnt_ld_val[i]),
      .q     (cnt_q[i])
    );
  end

  // Underflow from zero toggles every bit, so wrap needs no load; the other
  // modes override the toggle chain through the load path.
  always_comb begin
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    reload_d   = reload_q;
    done_d     = done_q;
    bt_d       = 1'b0;
    if (load) begin
      cnt_ld     = 1'b1;
      cnt_ld_val = din;
      reload_d   = din;
      done_d     = 1'b0;
    end else if (en && cnt_zero) begin
      unique case (mode_s)
        MODE_RELOAD: begin
          cnt_ld     = 1'b1;
          cnt_ld_val = reload_q;
          bt_d       = 1'b1;
        end
        MODE_ONESHOT: begin
          cnt_ld     = 1'b1;
          cnt_ld_val = '0;
          bt_d       = ~done_q;
          done_d     = 1'b1;
        end
        default: begin
          bt_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q <= RST_VAL;
      done_q   <= 1'b0;
      bt_q     <= 1'b0;
    end else begin
      reload_q <= reload_d;
      done_q   <= done_d;
      bt_q     <= bt_d;
    end
  end

  assign out  = cnt_q;
  assign bt   = bt_q;
  assign zero = cnt_zero;
  assign done = done_q;

endmodule

// File: tb/tb_down_counter32.sv
// Directed bench for down_counter32 with a behavioural reference model.
module tb_down_counter32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [4:0] din;
  logic [1:0] mode;
  logic [4:0] out;
  logic       bt;
  logic       zero;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  int m_out, m_rel, m_done, m_bt;

  down_counter32 #(
    .WIDTH   (5),
    .RST_VAL (5'd31)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .load  (load),
    .din   (din),
    .mode  (mode),
    .out   (out),
    .bt    (bt),
    .zero  (zero),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Reference: counts as an integer, applying the mode rules on underflow.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out <= 31; m_rel <= 31; m_done <= 0; m_bt <= 0;
    end else if (load) begin
      m_out <= int'(din); m_rel <= int'(din); m_done <= 0; m_bt <= 0;
    end else if (en) begin
      if (m_out != 0) begin
        m_out <= m_out - 1; m_bt <= 0;
      end else if (mode == 2'b01) begin
        m_out <= m_rel; m_bt <= 1;
      end else if (mode == 2'b10) begin
        m_bt <= (m_done == 0) ? 1 : 0; m_done <= 1;
      end else begin
        m_out <= 31; m_bt <= 1;
      end
    end else begin
      m_bt <= 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc.out",  int'(out),  m_out);
      chk("cyc.bt",   int'(bt),   m_bt);
      chk("cyc.zero", int'(zero), (m_out == 0) ? 1 : 0);
      chk("cyc.done", int'(done), m_done);
    end
  end

  task automatic expect_st(input string name, input int e_out, input int e_bt,
                           input int e_zero, input int e_done);
    chk({name, ".out"},   int'(out),  e_out);
    chk({name, ".bt"},    int'(bt),   e_bt);
    chk({name, ".zero"},  int'(zero), e_zero);
    chk({name, ".done"},  int'(done), e_done);
    chk({name, ".m_out"}, m_out,      e_out);
    chk({name, ".m_bt"},  m_bt,       e_bt);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [1:0] m, input logic [4:0] v);
    mode = m; din = v; load = 1'b1; en = 1'b0;
    tick();
    load = 1'b0;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int e_wrap[5];
    int e_rel[9];
    int gap_en[7];
    int gap_out[7];
    int gap_bt[7];
    e_wrap  = '{2, 1, 0, 31, 30};
    e_rel   = '{1, 0, 2, 1, 0, 2, 1, 0, 2};
    gap_en  = '{1, 0, 0, 1, 0, 1, 1};
    gap_out = '{0, 0, 0, 1, 1, 0, 1};
    gap_bt  = '{0, 0, 0, 1, 0, 0, 1};

    rst_n = 1'b1; en = 1'b0; load = 1'b0; din = '0; mode = 2'b00;
    #1 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    expect_st("rst", 31, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      expect_st("idle", 31, 0, 0, 0);
    end
    do_load(2'b00, 5'd5);
    expect_st("ld5", 5, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1 expect_st("async_rst", 31, 0, 0, 0);
    #2 rst_n = 1'b1;

    do_load(2'b00, 5'd3);
    expect_st("wrap.ld", 3, 0, 0, 0);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_st("wrap", e_wrap[i], (e_wrap[i] == 31) ? 1 : 0, (e_wrap[i] == 0) ? 1 : 0, 0);
    end

    do_load(2'b01, 5'd2);
    expect_st("rel.ld", 2, 0, 0, 0);
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      expect_st("rel", e_rel[i], (e_rel[i] == 2) ? 1 : 0, (e_rel[i] == 0) ? 1 : 0, 0);
    end

    do_load(2'b01, 5'd1);
    for (int i = 0; i < 7; i++) begin
      en = gap_en[i][0];
      tick();
      expect_st("gap", gap_out[i], gap_bt[i], (gap_out[i] == 0) ? 1 : 0, 0);
    end

    do_load(2'b01, 5'd0);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_st("rel0", 0, 1, 1, 0);
    end

    do_load(2'b10, 5'd1);
    expect_st("os.ld", 1, 0, 0, 0);
    en = 1'b1;
    tick(); expect_st("os0", 0, 0, 1, 0);
    tick(); expect_st("os1", 0, 1, 1, 1);
    tick(); expect_st("os2", 0, 0, 1, 1);
    tick(); expect_st("os3", 0, 0, 1, 1);
    mode = 2'b00;
    tick(); expect_st("os.sticky", 31, 1, 0, 1);
    do_load(2'b10, 5'd4);
    expect_st("os.reld", 4, 0, 0, 0);

    do_load(2'b00, 5'd0);
    expect_st("pri.ld0", 0, 0, 1, 0);
    din = 5'd7; load = 1'b1; en = 1'b1;
    tick();
    load = 1'b0; en = 1'b0;
    expect_st("pri", 7, 0, 0, 0);

    do_load(2'b11, 5'd0);
    en = 1'b1;
    tick();
    en = 1'b0;
    expect_st("mode11", 31, 1, 0, 0);
    #1 rst_n = 1'b0;
    #1 expect_st("bt_cancel", 31, 0, 0, 0);
    #2 rst_n = 1'b1;

    do_load(2'b01, 5'd9);
    en = 1'b1;
    for (int v = 8; v >= 3; v--) begin
      tick();
      expect_st("mid", v, 0, 0, 0);
    end
    #1 rst_n = 1'b0;
    #1 expect_st("mid.rst", 31, 0, 0, 0);
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk("post.out", int'(out), 31 - k);
      chk("post.bt", int'(bt), 0);
    end
    tick();
    expect_st("post.reload", 31, 1, 0, 0);
    en = 1'b0;
    tick();

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
